// File: rtl/hpdcache_core_req_arbiter_if.sv
// Core-side request/response bundle between NREQ requesters and one HPDcache requester port.
// The arbiter takes the slave view; the core side (or a bench) takes the master view.
interface hpdcache_core_req_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned SID_W = 3,
  parameter int unsigned REQ_W = 128,
  parameter int unsigned RSP_W = 80,
  parameter int unsigned CNT_W = 4
);
  logic [NREQ-1:0]             req_valid_i;
  logic [NREQ-1:0]             req_ready_o;
  logic [NREQ-1:0][REQ_W-1:0]  req_i;
  logic [NREQ-1:0]             req_need_rsp_i;
  logic                        cache_req_valid_o;
  logic                        cache_req_ready_i;
  logic [REQ_W-1:0]            cache_req_o;
  logic [SID_W-1:0]            cache_req_sid_o;
  logic                        cache_rsp_valid_i;
  logic [RSP_W-1:0]            cache_rsp_i;
  logic [SID_W-1:0]            cache_rsp_sid_i;
  logic [NREQ-1:0]             rsp_valid_o;
  logic [NREQ-1:0][RSP_W-1:0]  rsp_o;
  logic [NREQ-1:0][CNT_W-1:0]  outstanding_o;
  logic                        orphan_rsp_o;
  logic                        idle_o;

  modport slave (
    input  req_valid_i, req_i, req_need_rsp_i, cache_req_ready_i,
           cache_rsp_valid_i, cache_rsp_i, cache_rsp_sid_i,
    output req_ready_o, cache_req_valid_o, cache_req_o, cache_req_sid_o,
           rsp_valid_o, rsp_o, outstanding_o, orphan_rsp_o, idle_o
  );

  modport master (
    output req_valid_i, req_i, req_need_rsp_i, cache_req_ready_i,
           cache_rsp_valid_i, cache_rsp_i, cache_rsp_sid_i,
    input  req_ready_o, cache_req_valid_o, cache_req_o, cache_req_sid_o,
           rsp_valid_o, rsp_o, outstanding_o, orphan_rsp_o, idle_o
  );
endinterface

// File: rtl/hpdcache_core_req_arbiter.sv
// N-requester front-end for one HPDcache core port: RR/fixed-priority arbitration into a
// registered output stage, per-requester outstanding throttling and SID-based response routing.
module hpdcache_core_req_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned SID_W     = 3,
  parameter int unsigned REQ_W     = 128,
  parameter int unsigned RSP_W     = 80,
  parameter int unsigned MAX_OUTST = 8,
  parameter bit          RR_EN     = 1'b1,
  parameter int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  hpdcache_core_req_arbiter_if.slave bus
);

  logic [NREQ-1:0]            eligible;
  logic [NREQ-1:0]            grant;
  logic [NREQ-1:0]            inc;
  logic [NREQ-1:0]            dec;
  logic [NREQ-1:0]            dec_hit;
  logic [NREQ-1:0]            orphan_vec;
  logic [SID_W-1:0]           grant_idx;
  logic [SID_W-1:0]           ptr_q;
  logic [SID_W-1:0]           sid_q;
  logic [REQ_W-1:0]           req_mux;
  logic [REQ_W-1:0]           req_q;
  logic [NREQ-1:0][CNT_W-1:0] cnt_q;
  logic [NREQ-1:0][CNT_W-1:0] cnt_d;
  logic                       found;
  logic                       load;
  logic                       hs;
  logic                       sid_in_range;
  logic                       orphan_now;
  logic                       valid_q;
  logic                       valid_d;
  logic                       orphan_q;
  logic                       idle_q;
  logic                       idle_d;

  // A requester that needs a response is held off once its outstanding budget is used up.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      eligible[i] = bus.req_valid_i[i] &&
                    !(bus.req_need_rsp_i[i] && (cnt_q[i] == CNT_W'(MAX_OUTST)));
    end
  end

  // Two-pass circular search: indices at/after the pointer first, then wrap to the bottom.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && eligible[i] && (!RR_EN || (i >= int'(ptr_q)))) begin
        found     = 1'b1;
        grant_idx = SID_W'(i);
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && eligible[i]) begin
        found     = 1'b1;
        grant_idx = SID_W'(i);
      end
    end
  end

  always_comb begin
    grant   = '0;
    req_mux = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      grant[i] = found && (grant_idx == SID_W'(i));
      if (grant[i]) req_mux = req_mux | bus.req_i[i];
    end
  end

  assign load = !valid_q || bus.cache_req_ready_i;
  assign hs   = found && load;

  // Response decode; an orphan is dropped entirely so it cannot corrupt a counter.
  always_comb begin
    inc          = '0;
    dec_hit      = '0;
    orphan_vec   = '0;
    sid_in_range = (32'(bus.cache_rsp_sid_i) < NREQ);
    for (int i = 0; i < int'(NREQ); i++) begin
      inc[i]        = hs && grant[i] && bus.req_need_rsp_i[i];
      dec_hit[i]    = bus.cache_rsp_valid_i && (bus.cache_rsp_sid_i == SID_W'(i));
      orphan_vec[i] = dec_hit[i] && (cnt_q[i] == '0) && !inc[i];
    end
    orphan_now = bus.cache_rsp_valid_i && (!sid_in_range || (|orphan_vec));
    dec        = dec_hit & {NREQ{!orphan_now}};
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (inc[i] && !dec[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!inc[i] && dec[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  assign valid_d = load ? hs : valid_q;
  assign idle_d  = !valid_d && (cnt_d == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      req_q    <= '0;
      sid_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      if (hs) begin
        req_q <= req_mux;
        sid_q <= grant_idx;
        ptr_q <= (grant_idx == SID_W'(NREQ - 1)) ? '0 : grant_idx + SID_W'(1);
      end
      if (orphan_now) orphan_q <= 1'b1;
    end
  end

  assign bus.req_ready_o       = grant & {NREQ{load}};
  assign bus.cache_req_valid_o = valid_q;
  assign bus.cache_req_o       = req_q;
  assign bus.cache_req_sid_o   = sid_q;
  assign bus.rsp_valid_o       = dec;
  assign bus.rsp_o             = {NREQ{bus.cache_rsp_i}};
  assign bus.outstanding_o     = cnt_q;
  assign bus.orphan_rsp_o      = orphan_q;
  assign bus.idle_o            = idle_q;

endmodule

// File: tb/tb_hpdcache_core_req_arbiter.sv
// Scoreboard bench: a round-robin instance checked against a cycle model every cycle,
// plus a fixed-priority instance checked with a directed sequence.
module tb_hpdcache_core_req_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned SID_W     = 3;
  localparam int unsigned REQ_W     = 32;
  localparam int unsigned RSP_W     = 16;
  localparam int unsigned MAX_OUTST = 8;
  localparam int unsigned CNT_W     = 4;

  typedef struct {
    int               sid;
    logic [REQ_W-1:0] data;
  } sb_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sb_t  sbq[$];
  int   fpq[$];
  int   m_cnt[NREQ];
  int   m_ptr;
  bit   m_valid;
  bit   m_orph;
  bit   m_idle;

  hpdcache_core_req_arbiter_if #(.NREQ(NREQ), .SID_W(SID_W), .REQ_W(REQ_W), .RSP_W(RSP_W),
                                 .CNT_W(CNT_W)) bus_rr ();
  hpdcache_core_req_arbiter_if #(.NREQ(NREQ), .SID_W(SID_W), .REQ_W(REQ_W), .RSP_W(RSP_W),
                                 .CNT_W(CNT_W)) bus_fp ();

  hpdcache_core_req_arbiter #(.NREQ(NREQ), .SID_W(SID_W), .REQ_W(REQ_W), .RSP_W(RSP_W),
                              .MAX_OUTST(MAX_OUTST), .RR_EN(1'b1), .CNT_W(CNT_W)) u_rr (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_rr)
  );

  hpdcache_core_req_arbiter #(.NREQ(NREQ), .SID_W(SID_W), .REQ_W(REQ_W), .RSP_W(RSP_W),
                              .MAX_OUTST(MAX_OUTST), .RR_EN(1'b0), .CNT_W(CNT_W)) u_fp (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    bus_rr.req_i = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Cycle model of the round-robin instance; checks outputs then advances its own state.
  always @(negedge clk) begin : mdl
    logic [NREQ-1:0]       elig;
    logic [NREQ-1:0]       exp_ready;
    logic [NREQ-1:0]       inc;
    logic [NREQ-1:0]       exp_rsp;
    logic [NREQ*CNT_W-1:0] exp_cnt;
    bit                    found;
    bit                    load;
    bit                    hs;
    bit                    orph_now;
    bit                    all_zero;
    int                    g;
    int                    sid;
    sb_t                   e;
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_orph  = 1'b0;
      m_idle  = 1'b1;
      for (int i = 0; i < int'(NREQ); i++) m_cnt[i] = 0;
      sbq.delete();
    end else begin
      found = 1'b0;
      g     = 0;
      for (int i = 0; i < int'(NREQ); i++) begin
        elig[i] = bus_rr.req_valid_i[i] &&
                  !(bus_rr.req_need_rsp_i[i] && (m_cnt[i] == int'(MAX_OUTST)));
        exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      end
      for (int k = 0; k < int'(NREQ); k++) begin
        if (!found && elig[(m_ptr + k) % int'(NREQ)]) begin
          found = 1'b1;
          g     = (m_ptr + k) % int'(NREQ);
        end
      end
      load      = !m_valid || bus_rr.cache_req_ready_i;
      hs        = found && load;
      exp_ready = hs ? NREQ'(1 << g) : '0;

      check_eq("req_ready", 64'(bus_rr.req_ready_o), 64'(exp_ready));
      check_eq("cache_valid", 64'(bus_rr.cache_req_valid_o), 64'(m_valid));
      check_eq("outstanding", 64'(bus_rr.outstanding_o), 64'(exp_cnt));
      check_eq("orphan", 64'(bus_rr.orphan_rsp_o), 64'(m_orph));
      check_eq("idle", 64'(bus_rr.idle_o), 64'(m_idle));
      if (m_valid) begin
        if (sbq.size() == 0) begin
          check_eq("sb_underflow", 64'(sbq.size()), 64'd1);
        end else begin
          check_eq("cache_sid", 64'(bus_rr.cache_req_sid_o), 64'(sbq[0].sid));
          check_eq("cache_req", 64'(bus_rr.cache_req_o), 64'(sbq[0].data));
        end
      end

      inc = '0;
      if (hs && bus_rr.req_need_rsp_i[g]) inc[g] = 1'b1;
      exp_rsp  = '0;
      orph_now = 1'b0;
      sid      = 0;
      if (bus_rr.cache_rsp_valid_i) begin
        sid = int'(bus_rr.cache_rsp_sid_i);
        if (sid >= int'(NREQ))                 orph_now = 1'b1;
        else if (m_cnt[sid] == 0 && !inc[sid]) orph_now = 1'b1;
        else                                   exp_rsp[sid] = 1'b1;
      end
      check_eq("rsp_valid", 64'(bus_rr.rsp_valid_o), 64'(exp_rsp));
      if (exp_rsp != '0) check_eq("rsp_data", 64'(bus_rr.rsp_o[sid]), 64'(bus_rr.cache_rsp_i));

      for (int i = 0; i < int'(NREQ); i++) m_cnt[i] = m_cnt[i] + int'(inc[i]) - int'(exp_rsp[i]);
      if (orph_now) m_orph = 1'b1;
      if (m_valid && bus_rr.cache_req_ready_i) void'(sbq.pop_front());
      if (hs) begin
        e.sid  = g;
        e.data = bus_rr.req_i[g];
        sbq.push_back(e);
        m_ptr = (g + 1) % int'(NREQ);
      end
      if (load) m_valid = hs;
      all_zero = 1'b1;
      for (int i = 0; i < int'(NREQ); i++) if (m_cnt[i] != 0) all_zero = 1'b0;
      m_idle = !m_valid && all_zero;
    end
  end

  task automatic rr_idle();
    bus_rr.req_valid_i       = '0;
    bus_rr.req_need_rsp_i    = '0;
    bus_rr.req_i             = '0;
    bus_rr.cache_req_ready_i = 1'b1;
    bus_rr.cache_rsp_valid_i = 1'b0;
    bus_rr.cache_rsp_i       = '0;
    bus_rr.cache_rsp_sid_i   = '0;
  endtask

  task automatic rsp(input int sid);
    bus_rr.cache_rsp_valid_i = 1'b1;
    bus_rr.cache_rsp_sid_i   = SID_W'(sid);
    bus_rr.cache_rsp_i       = RSP_W'($urandom());
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    rr_idle();
    bus_fp.req_valid_i       = '0;
    bus_fp.req_need_rsp_i    = '0;
    bus_fp.req_i             = '0;
    bus_fp.cache_req_ready_i = 1'b1;
    bus_fp.cache_rsp_valid_i = 1'b0;
    bus_fp.cache_rsp_i       = '0;
    bus_fp.cache_rsp_sid_i   = '0;

    @(negedge clk);
    check_eq("rst_valid", 64'(bus_rr.cache_req_valid_o), 64'd0);
    check_eq("rst_req", 64'(bus_rr.cache_req_o), 64'd0);
    check_eq("rst_sid", 64'(bus_rr.cache_req_sid_o), 64'd0);
    check_eq("rst_cnt", 64'(bus_rr.outstanding_o), 64'd0);
    check_eq("rst_orphan", 64'(bus_rr.orphan_rsp_o), 64'd0);
    check_eq("rst_idle", 64'(bus_rr.idle_o), 64'd1);

    step();
    rst = 1'b0;

    // All requesters streaming, no responses expected.
    for (int c = 0; c < 12; c++) begin
      bus_rr.req_valid_i = 4'hF;
      rand_payload();
      step();
    end

    // Cache back-pressure then release.
    bus_rr.cache_req_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_payload();
      step();
    end
    bus_rr.cache_req_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_payload();
      step();
    end

    // Requester 2 saturates its outstanding budget.
    bus_rr.req_valid_i    = 4'b0100;
    bus_rr.req_need_rsp_i = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      rand_payload();
      step();
    end
    @(negedge clk);
    check_eq("sat_cnt2", 64'(bus_rr.outstanding_o[2]), 64'd8);
    check_eq("sat_ready", 64'(bus_rr.req_ready_o), 64'd0);
    step();
    rsp(2);
    step();
    rsp(2);
    @(negedge clk);
    check_eq("same_cyc_rsp", 64'(bus_rr.rsp_valid_o), 64'b0100);
    check_eq("same_cyc_ready", 64'(bus_rr.req_ready_o), 64'b0100);
    step();
    bus_rr.cache_rsp_valid_i = 1'b0;
    step();
    bus_rr.req_valid_i    = '0;
    bus_rr.req_need_rsp_i = '0;
    for (int c = 0; c < 8; c++) begin
      rsp(2);
      step();
    end

    // Orphans: empty counter, then out-of-range SID.
    rsp(0);
    @(negedge clk);
    check_eq("orphan_drop0", 64'(bus_rr.rsp_valid_o), 64'd0);
    step();
    rsp(5);
    step();
    bus_rr.cache_rsp_valid_i = 1'b0;
    @(negedge clk);
    check_eq("orphan_sticky", 64'(bus_rr.orphan_rsp_o), 64'd1);
    step();

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      bus_rr.req_valid_i       = NREQ'($urandom());
      bus_rr.req_need_rsp_i    = NREQ'($urandom());
      bus_rr.cache_req_ready_i = ($urandom_range(0, 3) != 0);
      rand_payload();
      if ($urandom_range(0, 2) == 0) rsp(int'($urandom_range(0, 4)));
      else bus_rr.cache_rsp_valid_i = 1'b0;
      step();
    end

    // Asynchronous reset in the middle of a burst.
    rr_idle();
    bus_rr.req_valid_i    = 4'hF;
    bus_rr.req_need_rsp_i = 4'hF;
    for (int c = 0; c < 3; c++) begin
      rand_payload();
      step();
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(bus_rr.cache_req_valid_o), 64'd0);
    check_eq("arst_req", 64'(bus_rr.cache_req_o), 64'd0);
    check_eq("arst_sid", 64'(bus_rr.cache_req_sid_o), 64'd0);
    check_eq("arst_cnt", 64'(bus_rr.outstanding_o), 64'd0);
    check_eq("arst_orphan", 64'(bus_rr.orphan_rsp_o), 64'd0);
    check_eq("arst_idle", 64'(bus_rr.idle_o), 64'd1);
    rr_idle();
    step();
    step();
    rst = 1'b0;

    // Fixed priority: 1 wins over 3 until it drops.
    for (int c = 0; c < 6; c++) begin
      logic [NREQ-1:0] exp_rdy;
      bus_fp.req_valid_i = (c < 3) ? 4'b1010 : (c == 3) ? 4'b1000 : 4'b0000;
      bus_fp.req_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_rdy            = (c < 3) ? 4'b0010 : (c == 3) ? 4'b1000 : 4'b0000;
      if (c < 3)  fpq.push_back(1);
      if (c == 3) fpq.push_back(3);
      @(negedge clk);
      check_eq("fp_ready", 64'(bus_fp.req_ready_o), 64'(exp_rdy));
      if (c == 0 || c == 5) check_eq("fp_valid", 64'(bus_fp.cache_req_valid_o), 64'd0);
      if (bus_fp.cache_req_valid_o) begin
        if (fpq.size() == 0) check_eq("fp_underflow", 64'(fpq.size()), 64'd1);
        else check_eq("fp_sid", 64'(bus_fp.cache_req_sid_o), 64'(fpq.pop_front()));
      end
      step();
    end
    check_eq("fp_q_empty", 64'(fpq.size()), 64'd0);

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hpdcache_core_req_arbiter.md
Name: hpdcache_core_req_arbiter

Overview:
Parametrised N-requester front-end that merges several core request channels into the single HPDcache core request port and routes responses back by source ID. It sits between the core-side load/store/prefetch units and one HPDcache requester port, and generalises the single-requester build to NREQ channels. It adds round-robin or fixed-priority arbitration, a registered output stage, and per-requester outstanding-request throttling. It also flags orphan responses.

Parameters:
NREQ, 4, number of requester channels (1..8)
SID_W, 3, source-ID width; NREQ <= 2**SID_W
REQ_W, 128, request payload width (packed hpdcache_req_t minus sid)
RSP_W, 80, response payload width (packed hpdcache_rsp_t minus sid)
MAX_OUTST, 8, max outstanding response-expecting requests per requester (1..255)
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
CNT_W, $clog2(MAX_OUTST+1), derived outstanding-counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  NREQ  per-requester request valid
req_ready_o  out  NREQ  per-requester request ready
req_i  in  NREQ x REQ_W  per-requester request payload
req_need_rsp_i  in  NREQ  request expects a response (counts as outstanding)
cache_req_valid_o  out  1  request valid to cache
cache_req_ready_i  in  1  cache ready
cache_req_o  out  REQ_W  registered payload to cache
cache_req_sid_o  out  SID_W  source ID = granted requester index
cache_rsp_valid_i  in  1  cache response valid
cache_rsp_i  in  RSP_W  response payload
cache_rsp_sid_i  in  SID_W  response source ID
rsp_valid_o  out  NREQ  routed response valid
rsp_o  out  NREQ x RSP_W  routed response payload (broadcast, qualified by rsp_valid_o)
outstanding_o  out  NREQ x CNT_W  per-requester outstanding count
orphan_rsp_o  out  1  sticky error: response with no matching outstanding request
idle_o  out  1  output register empty and all counters zero

Behaviour:
- Reset values (async assert, sync-safe deassert): cache_req_valid_o=0, cache_req_o=0, cache_req_sid_o=0, all counters 0, RR pointer 0, orphan_rsp_o=0, idle_o=1.
- Eligibility: requester i is eligible if req_valid_i[i]=1 and NOT (req_need_rsp_i[i]=1 and outstanding[i]==MAX_OUTST).
- Arbitration (combinational, one grant per cycle):
  - RR_EN=1: first eligible index at or after the pointer, searching circularly.
  - RR_EN=0: lowest eligible index.
- Output register "load" condition: !cache_req_valid_o || cache_req_ready_i.
- req_ready_o[i] = grant[i] && load. Handshake is req_valid_i[i] && req_ready_o[i]. No ready is ever given to an ineligible requester.
- On handshake, the output register captures req_i[grant] and sid=grant, and cache_req_valid_o=1 the next cycle. Latency is 1 cycle. Full throughput of 1 req/cycle is achieved while cache_req_ready_i=1.
- While cache_req_valid_o=1 and cache_req_ready_i=0, payload and sid are held stable.
- Output register clears (valid=0) when cache_req_ready_i=1 and there is no new handshake.
- RR pointer becomes (grant+1) mod NREQ on each handshake only. It is unchanged on a stall.
- Counters:
  - outstanding[i] increments on a handshake by i with req_need_rsp_i=1.
  - It decrements on cache_rsp_valid_i with sid==i.
  - Simultaneous increment and decrement on the same i leaves the count unchanged.
  - The count never exceeds MAX_OUTST.
- Response routing is combinational, 0 latency: rsp_valid_o[sid]=cache_rsp_valid_i and all others 0.
- Orphan response = cache_rsp_valid_i with sid>=NREQ, or sid==i while outstanding[i]==0 and no increment for i occurs in the same cycle.
  - The response is dropped: rsp_valid_o stays all 0 and no counter changes.
  - orphan_rsp_o is set and held until reset.
- idle_o is registered and reflects the state after the current edge.
- NREQ=1: arbiter degenerates to a pass-through with the output register; the pointer stays 0.

Test Plan:
- Reset, then all 4 requesters assert valid continuously with need_rsp=0 and cache ready=1 → cache_req_sid_o sequence 0,1,2,3,0,…, one request per cycle, first valid 1 cycle after the first handshake.
- RR_EN=0, requesters 1 and 3 valid → only 1 is granted while it stays valid; 3 is granted the cycle after 1 drops.
- Cache ready held 0 for 5 cycles with valid=1 → cache_req_o/sid stable, req_ready_o all 0. Release → accepted next edge, new request loaded in the same cycle.
- Requester 2 issues 8 need_rsp requests (MAX_OUTST=8) with no responses → outstanding_o[2]=8 and req_ready_o[2]=0. One response with sid=2 → count 7, and 2 is granted again.
- Response with sid=2 in the same cycle as a handshake by 2 (need_rsp=1) → count unchanged, rsp_valid_o=4'b0100.
- Response with sid=5 (NREQ=4), and response with sid=0 while count is 0 → rsp_valid_o=0, orphan_rsp_o=1 sticky. Asserting rst_i mid-burst → all outputs return to reset values asynchronously.
